conv_frame_streamer: RTL and testbench
======================================

// Module: conv_frame_streamer
// PURPOSE
//  Frame source that feeds the convolution line buffer. Host loads one frame into internal RAM, then
//  pulses start; block emits pixels in raster order (row 0 col 0 first) as a valid/ready stream.
//  Its out_point/valid_out/frame_column_size/frame_row_size drive the line buffer's pixel input directly.
// PARAMETERS
//  DATA_WIDTH      8     pixel width, bits
//  BUFFER_LENGTH   2000  max line length; sets dimension width DW = $clog2(BUFFER_LENGTH)
//  FRAME_DEPTH     4096  frame RAM entries; AW = $clog2(FRAME_DEPTH)
//  KERNEL_ROW_SIZE 3     kernel height/width; pad P = KERNEL_ROW_SIZE/2 (ZERO_PAD_EN only)
// PORTS
//  clk               in   1           system clock, all logic on rising edge
//  rst               in   1           asynchronous reset, active-high
//  wr_en             in   1           host write strobe (honoured in IDLE only)
//  wr_addr           in   AW          host write address, raster index
//  wr_data           in   DATA_WIDTH  host write pixel
//  cfg_cols          in   DW          frame width in pixels, sampled on start
//  cfg_rows          in   DW          frame height in pixels, sampled on start
//  start             in   1           one-cycle pulse, begin streaming
//  ready_in          in   1           downstream accepts out_point this cycle
//  out_point         out  DATA_WIDTH  pixel data
//  valid_out         out  1           out_point valid
//  frame_column_size out  DW          latched streamed width (incl. padding)
//  frame_row_size    out  DW          latched streamed height (incl. padding)
//  busy              out  1           high from accepted start until last beat accepted
//  frame_done        out  1           one-cycle pulse on acceptance of last beat
//  wr_err            out  1           sticky: write attempted while busy; cleared by start in IDLE
// BEHAVIOUR
//  Reset: all outputs 0, FSM IDLE, counters 0, skid buffer empty. Reset mid-frame aborts; no frame_done.
//  FSM: IDLE -> STREAM on start when cfg_cols!=0 && cfg_rows!=0 (else stay IDLE, no pulse).
//       STREAM -> DRAIN when final RAM read issued; DRAIN -> IDLE when last beat accepted.
//  start while busy ignored. wr_en while busy: write dropped, wr_err<=1.
//  Beat transfer = valid_out && ready_in. While valid_out && !ready_in, out_point held stable.
//  RAM read latency 1 cycle; 2-entry skid buffer so a read is issued each cycle the buffer has room;
//  sustained ready_in=1 gives one beat per cycle, no bubbles after first.
//  Latency: start at cycle T -> first valid_out at T+2.
//  Counters col 0..cols-1, row 0..rows-1; col wraps to 0 and row increments at cols-1;
//  read address = row*cols+col kept as incrementing AW-bit pointer (no multiplier).
//  cols*rows > FRAME_DEPTH is a configuration error; address wraps modulo FRAME_DEPTH.
//  frame_done and busy fall in the same cycle as the last accepted beat; start is accepted
//  the following cycle at the earliest.
// CONFIGURATION
//  ZERO_PAD_EN defined: stream is (cols+2P)x(rows+2P); border beats carry 0 without RAM read;
//   frame_column_size=cols+2P, frame_row_size=rows+2P; width computed in DW+1 bits, saturated.
//  ZERO_PAD_EN undefined: stream is exactly cols x rows; frame_*_size = cfg_* .
// STRUCTURE
//  conv_pkg: state encoding (IDLE/STREAM/DRAIN), AW/DW width helpers, pad constant P.
//  Frame RAM: trueDualMemReadFirst instance (port A host write, port B stream read).
//  Sub-module stream_skid_buffer (2-entry valid/ready register slice) absorbs read latency.
// TESTING
//  4x3 frame, data=index, ready_in=1 -> 12 beats 0..11 in order, frame_done with beat 11, first valid T+2.
//  Same frame, ready_in toggled 1,0,0,1... -> same 12 values, no loss/duplication, out_point stable in stalls.
//  start with cfg_cols=0 -> busy stays 0, no valid_out, no frame_done.
//  wr_en and start during STREAM -> write dropped, wr_err=1, stream unaffected; next start clears wr_err.
//  rst asserted at beat 5 -> outputs 0 next edge; new start replays from beat 0.
//  ZERO_PAD_EN, 2x2 frame {1,2,3,4}, P=1 -> 16 beats 0,0,0,0,0,1,2,0,0,3,4,0,0,0,0,0; sizes 4x4.

Source files
------------

// File: rtl/conv_pkg.sv
// conv_pkg: shared definitions for the convolution frame streamer.
//   state_t   - streamer FSM encoding (IDLE / STREAM / DRAIN)
//   width_of  - bit width needed to index n entries (minimum 1)
//   pad_of    - zero-pad border width for a square kernel
package conv_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_DRAIN  = 2'd2
    } state_t;

    function automatic int width_of(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int pad_of(input int kernel);
        return kernel / 2;
    endfunction

    localparam int KERNEL_ROW_SIZE_DEFAULT = 3;
    localparam int PAD_DEFAULT             = pad_of(KERNEL_ROW_SIZE_DEFAULT);

endpackage

// File: rtl/stream_skid_buffer.sv
// stream_skid_buffer: 2-entry valid/ready register slice.
// Ports: clk, rst (async, active-high); in_valid/in_data push side (the
//        caller guarantees it never pushes into a full buffer that is not
//        popping); out_valid/out_data/out_ready pop side; count = occupancy.
// out_data comes straight from the head register, so it is stable while
// out_valid && !out_ready.
module stream_skid_buffer #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  out_ready,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [1:0]            count
);

    logic [DATA_WIDTH-1:0] ent [2];
    logic                  wr_ptr;
    logic                  rd_ptr;
    logic                  pop;

    assign out_valid = (count != 2'd0);
    assign out_data  = ent[rd_ptr];
    assign pop       = out_valid && out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ent[0] <= '0;
            ent[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (in_valid) begin
                ent[wr_ptr] <= in_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) rd_ptr <= ~rd_ptr;
            count <= count + {1'b0, in_valid} - {1'b0, pop};
        end
    end

endmodule

// File: rtl/trueDualMemReadFirst.sv
// trueDualMemReadFirst: true dual-port RAM, read-before-write on each port,
// one-cycle registered read latency. No reset on storage or read registers.
// Ports: clk; port A (a_en, a_we, a_addr, a_din, a_dout);
//        port B (b_en, b_we, b_addr, b_din, b_dout).
// If both ports write the same address in one cycle, port B wins.
module trueDualMemReadFirst #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 4096,
    parameter int AW         = 12
) (
    input  logic                  clk,
    input  logic                  a_en,
    input  logic                  a_we,
    input  logic [AW-1:0]         a_addr,
    input  logic [DATA_WIDTH-1:0] a_din,
    output logic [DATA_WIDTH-1:0] a_dout,
    input  logic                  b_en,
    input  logic                  b_we,
    input  logic [AW-1:0]         b_addr,
    input  logic [DATA_WIDTH-1:0] b_din,
    output logic [DATA_WIDTH-1:0] b_dout
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Both ports in one process so the array has a single driver.
    always_ff @(posedge clk) begin
        if (a_en) begin
            a_dout <= mem[a_addr];
            if (a_we) mem[a_addr] <= a_din;
        end
        if (b_en) begin
            b_dout <= mem[b_addr];
            if (b_we) mem[b_addr] <= b_din;
        end
    end

endmodule

// File: rtl/conv_frame_streamer.sv
// conv_frame_streamer: frame source for the convolution line buffer.
// Host writes one frame into the internal RAM while idle, then pulses start;
// pixels stream out in raster order on a valid/ready interface.
// Ports:
//   clk, rst                  clock, async active-high reset
//   wr_en/wr_addr/wr_data     host frame write (accepted only while idle)
//   cfg_cols/cfg_rows         frame size, sampled on start
//   start                     one-cycle pulse to begin streaming
//   ready_in                  downstream accept
//   out_point/valid_out       pixel stream
//   frame_column_size/_row_size  latched streamed size (including padding)
//   busy                      frame in progress
//   frame_done                pulse on acceptance of the last beat
//   wr_err                    sticky: write attempted while busy
// Build option: define ZERO_PAD_EN to surround the frame with a zero border
// of KERNEL_ROW_SIZE/2 pixels on every side.
module conv_frame_streamer
    import conv_pkg::*;
#(
    parameter int  DATA_WIDTH      = 8,
    parameter int  BUFFER_LENGTH   = 2000,
    parameter int  FRAME_DEPTH     = 4096,
    parameter int  KERNEL_ROW_SIZE = 3,
    localparam int DW              = width_of(BUFFER_LENGTH),
    localparam int AW              = width_of(FRAME_DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [AW-1:0]         wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [DW-1:0]         cfg_cols,
    input  logic [DW-1:0]         cfg_rows,
    input  logic                  start,
    input  logic                  ready_in,
    output logic [DATA_WIDTH-1:0] out_point,
    output logic                  valid_out,
    output logic [DW-1:0]         frame_column_size,
    output logic [DW-1:0]         frame_row_size,
    output logic                  busy,
    output logic                  frame_done,
    output logic                  wr_err
);

`ifdef ZERO_PAD_EN
    localparam bit PAD_EN = 1'b1;
`else
    localparam bit PAD_EN = 1'b0;
`endif
    // With padding disabled the border is zero wide and every beat is a RAM read.
    localparam int            P      = PAD_EN ? pad_of(KERNEL_ROW_SIZE) : 0;
    localparam logic [DW:0]   PW     = (DW+1)'(P);
    localparam logic [DW:0]   PW2    = (DW+1)'(2 * P);
    localparam logic [DW-1:0] ONE_D  = DW'(1);
    localparam logic [AW-1:0] ONE_A  = AW'(1);

    // Streamed dimension = raw + 2P, computed one bit wider and saturated.
    function automatic logic [DW-1:0] stream_dim(input logic [DW-1:0] d);
        logic [DW:0] w;
        w = {1'b0, d} + PW2;
        return w[DW] ? '1 : w[DW-1:0];
    endfunction

    state_t                state, state_nx;
    logic [DW-1:0]         cols_r, rows_r;     // raw frame size of this run
    logic [DW-1:0]         col, row;           // position in the streamed frame
    logic [AW-1:0]         ptr;                // next RAM read address
    logic                  rd_vld, rd_pad;     // beat in the RAM read stage
    logic [DATA_WIDTH-1:0] ram_dout;
    logic [DATA_WIDTH-1:0] ram_a_dout_unused;
    logic [DATA_WIDTH-1:0] stage_data;
    logic [1:0]            level;

    logic [DW-1:0]         sc, sr, rc, rr;
    logic                  start_ok, pop, room, interior;
    logic                  issue, last_issue, last_beat;

    assign busy       = (state != ST_IDLE);
    assign stage_data = rd_pad ? '0 : ram_dout;

    always_comb begin
        state_nx   = state;
        frame_done = 1'b0;
        sc         = frame_column_size;
        sr         = frame_row_size;
        rc         = cols_r;
        rr         = rows_r;
        // The first beat is issued in the start cycle itself, before the
        // sizes are latched, so use the cfg inputs while idle.
        if (state == ST_IDLE) begin
            sc = stream_dim(cfg_cols);
            sr = stream_dim(cfg_rows);
            rc = cfg_cols;
            rr = cfg_rows;
        end

        start_ok = (state == ST_IDLE) && start &&
                   (cfg_cols != '0) && (cfg_rows != '0);
        pop      = valid_out && ready_in;
        // Keep buffered + in-flight beats <= 2 after this cycle's issue.
        room     = ({1'b0, level} + {2'b0, rd_vld} - {2'b0, pop}) <= 3'd1;
        // col-P wraps to a huge value inside the left/top border, so one
        // unsigned compare per axis covers both edges.
        interior = (({1'b0, col} - PW) < {1'b0, rc}) &&
                   (({1'b0, row} - PW) < {1'b0, rr});

        issue      = start_ok || ((state == ST_STREAM) && room);
        last_issue = issue && (col == sc - ONE_D) && (row == sr - ONE_D);
        last_beat  = (state == ST_DRAIN) && pop && (level == 2'd1) && !rd_vld;
        frame_done = last_beat;

        case (state)
            ST_IDLE:   if (start_ok)   state_nx = last_issue ? ST_DRAIN : ST_STREAM;
            ST_STREAM: if (last_issue) state_nx = ST_DRAIN;
            ST_DRAIN:  if (last_beat)  state_nx = ST_IDLE;
            default:                   state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state             <= ST_IDLE;
            cols_r            <= '0;
            rows_r            <= '0;
            col               <= '0;
            row               <= '0;
            ptr               <= '0;
            rd_vld            <= 1'b0;
            rd_pad            <= 1'b0;
            frame_column_size <= '0;
            frame_row_size    <= '0;
            wr_err            <= 1'b0;
        end else begin
            state  <= state_nx;
            rd_vld <= issue;
            rd_pad <= issue && !interior;

            if (issue) begin
                if (last_issue) begin
                    // Park counters at zero so the next start reads from 0.
                    col <= '0;
                    row <= '0;
                    ptr <= '0;
                end else begin
                    if (col == sc - ONE_D) begin
                        col <= '0;
                        row <= row + ONE_D;
                    end else begin
                        col <= col + ONE_D;
                    end
                    if (interior) ptr <= ptr + ONE_A;
                end
            end

            if (start_ok) begin
                cols_r            <= cfg_cols;
                rows_r            <= cfg_rows;
                frame_column_size <= stream_dim(cfg_cols);
                frame_row_size    <= stream_dim(cfg_rows);
            end

            if ((state == ST_IDLE) && start)      wr_err <= 1'b0;
            else if (wr_en && (state != ST_IDLE)) wr_err <= 1'b1;
        end
    end

    trueDualMemReadFirst #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (FRAME_DEPTH),
        .AW         (AW)
    ) u_frame_ram (
        .clk    (clk),
        .a_en   (wr_en && (state == ST_IDLE)),
        .a_we   (wr_en && (state == ST_IDLE)),
        .a_addr (wr_addr),
        .a_din  (wr_data),
        .a_dout (ram_a_dout_unused),
        .b_en   (issue && interior),
        .b_we   (1'b0),
        .b_addr (ptr),
        .b_din  ('0),
        .b_dout (ram_dout)
    );

    stream_skid_buffer #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_skid (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (rd_vld),
        .in_data   (stage_data),
        .out_ready (ready_in),
        .out_valid (valid_out),
        .out_data  (out_point),
        .count     (level)
    );

endmodule

// File: tb/tb_conv_frame_streamer.sv
// Self-checking bench for conv_frame_streamer. Expected beats are built from
// a copy of the host-written frame by walking the (padded) raster directly.
module tb_conv_frame_streamer;

    localparam int DATA_WIDTH = 8;
    localparam int AW         = 12;
    localparam int DW         = 11;
    localparam int DEPTH      = 4096;
`ifdef ZERO_PAD_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic                  wr_en = 1'b0;
    logic [AW-1:0]         wr_addr = '0;
    logic [DATA_WIDTH-1:0] wr_data = '0;
    logic [DW-1:0]         cfg_cols = '0;
    logic [DW-1:0]         cfg_rows = '0;
    logic                  start = 1'b0;
    logic                  ready_in = 1'b0;
    logic [DATA_WIDTH-1:0] out_point;
    logic                  valid_out;
    logic [DW-1:0]         frame_column_size;
    logic [DW-1:0]         frame_row_size;
    logic                  busy;
    logic                  frame_done;
    logic                  wr_err;

    int checks   = 0;
    int failures = 0;

    logic [7:0] frame_mem [DEPTH];
    int         exp_q [$];

    conv_frame_streamer dut (
        .clk               (clk),
        .rst               (rst),
        .wr_en             (wr_en),
        .wr_addr           (wr_addr),
        .wr_data           (wr_data),
        .cfg_cols          (cfg_cols),
        .cfg_rows          (cfg_rows),
        .start             (start),
        .ready_in          (ready_in),
        .out_point         (out_point),
        .valid_out         (valid_out),
        .frame_column_size (frame_column_size),
        .frame_row_size    (frame_row_size),
        .busy              (busy),
        .frame_done        (frame_done),
        .wr_err            (wr_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic rdy_pat(input int mode, input int cyc);
        case (mode)
            0:       return 1'b1;
            1:       return (cyc % 3) == 0;     // 1,0,0,1,0,0,...
            default: return 1'($urandom_range(0, 1));
        endcase
    endfunction

    // kind: 0 = index, 1 = random, 2 = index+1
    task automatic load_frame(input int n, input int kind);
        int v;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            v       = (kind == 0) ? i : (kind == 2) ? i + 1 : int'($urandom_range(0, 255));
            wr_en   = 1'b1;
            wr_addr = AW'(i);
            wr_data = 8'(v);
            frame_mem[i] = 8'(v);
        end
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic build_exp(input int c, input int r);
        exp_q.delete();
        for (int y = 0; y < r + 2 * P; y++)
            for (int x = 0; x < c + 2 * P; x++)
                if (y >= P && y < r + P && x >= P && x < c + P)
                    exp_q.push_back(int'(frame_mem[((y - P) * c + (x - P)) % DEPTH]));
                else
                    exp_q.push_back(0);
    endtask

    // Starts at a negedge; start is sampled at the following posedge (cyc 0).
    task automatic run_stream(input int c, input int r, input int mode,
                              input int abort_at, input bit inject);
        int         n;
        int         nbeats;
        int         first_cyc;
        int         done_cnt;
        bit         aborted;
        logic       prev_stall;
        logic [7:0] prev_pt;
        build_exp(c, r);
        n          = exp_q.size();
        nbeats     = 0;
        first_cyc  = -1;
        done_cnt   = 0;
        aborted    = 1'b0;
        prev_stall = 1'b0;
        prev_pt    = '0;
        cfg_cols   = DW'(c);
        cfg_rows   = DW'(r);
        for (int cyc = 0; cyc < 3000 && nbeats < n; cyc++) begin
            start    = (cyc == 0) || (inject && cyc == 4);
            wr_en    = inject && (cyc == 4);
            wr_addr  = AW'(c * r - 1);
            wr_data  = ~frame_mem[c * r - 1];
            ready_in = rdy_pat(mode, cyc);
            #1;
            if (cyc == 1) begin
                chk("busy_on", 32'(busy), 1);
                chk("wr_err_clr", 32'(wr_err), 0);
                chk("col_size", 32'(frame_column_size), c + 2 * P);
                chk("row_size", 32'(frame_row_size), r + 2 * P);
            end
            if (inject && cyc == 5) chk("wr_err_set", 32'(wr_err), 1);
            if (abort_at >= 0 && nbeats == abort_at && valid_out) begin
                rst = 1'b1;
                #1;
                chk("abort_outs", 32'({valid_out, busy, frame_done, out_point}), 0);
                rst     = 1'b0;
                aborted = 1'b1;
                break;
            end
            if (valid_out && first_cyc < 0) first_cyc = cyc;
            if (prev_stall) chk("stall_hold", 32'({valid_out, out_point}), 32'({1'b1, prev_pt}));
            if (frame_done) begin
                done_cnt++;
                chk("done_align", 32'(valid_out && ready_in && nbeats == n - 1), 1);
            end
            if (valid_out && ready_in) begin
                chk("beat", 32'(out_point), exp_q[nbeats]);
                nbeats++;
            end
            prev_stall = valid_out && !ready_in;
            prev_pt    = out_point;
            @(negedge clk);
        end
        start = 1'b0;
        wr_en = 1'b0;
        if (!aborted) begin
            chk("beat_count", nbeats, n);
            chk("first_lat", first_cyc, 2);
            chk("done_count", done_cnt, 1);
            chk("end_idle", 32'({busy, valid_out, frame_done}), 0);
        end
    endtask

    initial begin
        int  c;
        int  r;
        logic bad;

        @(negedge clk);
        @(negedge clk);
        chk("rst_valid", 32'(valid_out), 0);
        chk("rst_busy", 32'({busy, frame_done, wr_err}), 0);
        chk("rst_point", 32'(out_point), 0);
        chk("rst_sizes", 32'({frame_column_size, frame_row_size}), 0);
        rst = 1'b0;
        @(negedge clk);

        // 4x3, data = index: full rate, then 1,0,0 backpressure
        load_frame(12, 0);
        run_stream(4, 3, 0, -1, 1'b0);
        run_stream(4, 3, 1, -1, 1'b0);

        // zero width / zero height: start ignored
        bad = 1'b0;
        for (int k = 0; k < 2; k++) begin
            cfg_cols = (k == 0) ? DW'(0) : DW'(4);
            cfg_rows = (k == 0) ? DW'(3) : DW'(0);
            start    = 1'b1;
            ready_in = 1'b1;
            for (int j = 0; j < 6; j++) begin
                #1;
                bad = bad | busy | valid_out | frame_done;
                @(negedge clk);
                start = 1'b0;
            end
        end
        chk("zero_cfg", 32'(bad), 0);

        // write + start while streaming: write dropped, wr_err set
        run_stream(4, 3, 0, -1, 1'b1);
        chk("wr_err_hold", 32'(wr_err), 1);
        // next start clears wr_err (checked inside at cyc 1)
        run_stream(4, 3, 1, -1, 1'b0);

        // reset at beat 5, then full replay from beat 0
        run_stream(4, 3, 0, 5, 1'b0);
        @(negedge clk);
        run_stream(4, 3, 0, -1, 1'b0);

        // 2x2 {1,2,3,4} and 1x1 corner cases
        load_frame(4, 2);
        run_stream(2, 2, 0, -1, 1'b0);
        load_frame(1, 1);
        run_stream(1, 1, 1, -1, 1'b0);

        // random sizes, contents and backpressure
        for (int t = 0; t < 6; t++) begin
            c = int'($urandom_range(1, 8));
            r = int'($urandom_range(1, 6));
            load_frame(c * r, 1);
            run_stream(c, r, 2, -1, 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
